// File: rtl/color_matrix_nch.sv
// N-channel colour-correction matrix on AXI4-Stream: out = clip(round(A*in + OFFS)), with double-buffered coefficients.
// Latency 3 accepted cycles; s_tready_o = !m_tvalid_o | m_tready_i and all stages stall together.
module color_matrix_nch #(
    parameter int  PX_WIDTH    = 10,
    parameter int  CH_NUM      = 3,
    parameter int  FRACT_WIDTH = 10,
    parameter int  INT_WIDTH   = 3,
    localparam int COEF_WIDTH  = 1 + INT_WIDTH + FRACT_WIDTH,
    localparam int OFFS_WIDTH  = PX_WIDTH + 2 + FRACT_WIDTH,
    localparam int TDATA_WIDTH = ((PX_WIDTH * CH_NUM + 7) / 8) * 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [TDATA_WIDTH-1:0] s_tdata_i,
    input  logic                   s_tvalid_i,
    output logic                   s_tready_o,
    input  logic                   s_tlast_i,
    input  logic                   s_tuser_i,
    output logic [TDATA_WIDTH-1:0] m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic                   m_tlast_o,
    output logic                   m_tuser_o,
    input  logic                   bypass_i,
    input  logic                   coef_wr_i,
    input  logic [3:0]             coef_addr_i,
    input  logic [OFFS_WIDTH-1:0]  coef_wdata_i,
    output logic [OFFS_WIDTH-1:0]  coef_rdata_o,
    input  logic                   coef_apply_i,
    output logic                   coef_pend_o
);
    localparam int ROW    = CH_NUM + 1;
    localparam int NCOEF  = CH_NUM * ROW;
    localparam int DW     = PX_WIDTH * CH_NUM;
    localparam int PROD_W = COEF_WIDTH + PX_WIDTH + 1;
    localparam int ACC_W  = PX_WIDTH + COEF_WIDTH + 3;
    localparam logic signed [ACC_W-1:0]      HALF   = ACC_W'(2 ** (FRACT_WIDTH - 1));
    localparam logic signed [ACC_W-1:0]      PX_MAX = ACC_W'(2 ** PX_WIDTH - 1);
    localparam logic signed [OFFS_WIDTH-1:0] ONE    = OFFS_WIDTH'(2 ** FRACT_WIDTH);

    logic signed [OFFS_WIDTH-1:0] act_q [NCOEF];
    logic signed [OFFS_WIDTH-1:0] shd_q [NCOEF];
    logic signed [OFFS_WIDTH-1:0] shd_d [NCOEF];
    logic signed [OFFS_WIDTH-1:0] use_c [NCOEF];
    logic                         pend_q, pend_d, copy, en, in_hs, pipe_empty;
    logic [OFFS_WIDTH-1:0]        rdata_q, rdata_d;

    logic                         v1_q, v2_q, v3_q;
    logic                         last1_q, last2_q, last3_q;
    logic                         user1_q, user2_q, user3_q;
    logic                         byp1_q, byp2_q;
    logic [DW-1:0]                px1_q, px2_q;
    logic signed [PROD_W-1:0]     prod_d [CH_NUM][CH_NUM];
    logic signed [PROD_W-1:0]     prod_q [CH_NUM][CH_NUM];
    logic signed [OFFS_WIDTH-1:0] offs_q [CH_NUM];
    logic signed [ACC_W-1:0]      acc_d  [CH_NUM];
    logic signed [ACC_W-1:0]      acc_q  [CH_NUM];
    logic signed [ACC_W-1:0]      rnd;
    logic [TDATA_WIDTH-1:0]       dat_d, dat_q;
    logic                         unused_pad;

    assign unused_pad = ^s_tdata_i;

    // The SOF beat that triggers the copy must already see the new set, so S1 reads shadow in that cycle.
    always_comb begin
        en         = !v3_q || m_tready_i;
        in_hs      = s_tvalid_i && en;
        pipe_empty = !v1_q && !v2_q && !v3_q;
        copy       = ((pend_q || coef_apply_i) && in_hs && s_tuser_i)
                   || (pend_q && pipe_empty && !s_tvalid_i);
        pend_d     = !copy && (pend_q || coef_apply_i);
    end

    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NCOEF; k++) begin
            shd_d[k] = shd_q[k];
            use_c[k] = copy ? shd_q[k] : act_q[k];
            if (coef_addr_i == 4'(k)) begin
                rdata_d = act_q[k];
                if (coef_wr_i) begin
                    shd_d[k] = (k % ROW == CH_NUM) ? $signed(coef_wdata_i)
                             : OFFS_WIDTH'($signed(coef_wdata_i[COEF_WIDTH-1:0]));
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            for (int j = 0; j < CH_NUM; j++) begin
                prod_d[i][j] = PROD_W'($signed(use_c[i*ROW+j][COEF_WIDTH-1:0]))
                             * PROD_W'($signed({1'b0, s_tdata_i[j*PX_WIDTH +: PX_WIDTH]}));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            acc_d[i] = ACC_W'(offs_q[i]);
            for (int j = 0; j < CH_NUM; j++) begin
                acc_d[i] = acc_d[i] + ACC_W'(prod_q[i][j]);
            end
        end
    end

    always_comb begin
        dat_d = '0;
        rnd   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            rnd = (acc_q[i] + HALF) >>> FRACT_WIDTH;
            if (byp2_q)
                dat_d[i*PX_WIDTH +: PX_WIDTH] = px2_q[i*PX_WIDTH +: PX_WIDTH];
            else if (rnd[ACC_W-1])
                dat_d[i*PX_WIDTH +: PX_WIDTH] = '0;
            else if (rnd > PX_MAX)
                dat_d[i*PX_WIDTH +: PX_WIDTH] = '1;
            else
                dat_d[i*PX_WIDTH +: PX_WIDTH] = rnd[PX_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NCOEF; k++) begin
                act_q[k] <= (k % ROW == k / ROW) ? ONE : '0;
                shd_q[k] <= (k % ROW == k / ROW) ? ONE : '0;
            end
            for (int i = 0; i < CH_NUM; i++) begin
                for (int j = 0; j < CH_NUM; j++) prod_q[i][j] <= '0;
                offs_q[i] <= '0;
                acc_q[i]  <= '0;
            end
            pend_q  <= 1'b0;
            rdata_q <= '0;
            v1_q    <= 1'b0;  v2_q    <= 1'b0;  v3_q    <= 1'b0;
            last1_q <= 1'b0;  last2_q <= 1'b0;  last3_q <= 1'b0;
            user1_q <= 1'b0;  user2_q <= 1'b0;  user3_q <= 1'b0;
            byp1_q  <= 1'b0;  byp2_q  <= 1'b0;
            px1_q   <= '0;    px2_q   <= '0;
            dat_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
            shd_q   <= shd_d;
            if (copy) act_q <= shd_q;
            if (en) begin
                v1_q    <= s_tvalid_i;
                last1_q <= s_tlast_i;
                user1_q <= s_tuser_i;
                byp1_q  <= bypass_i;
                px1_q   <= s_tdata_i[DW-1:0];
                prod_q  <= prod_d;
                for (int i = 0; i < CH_NUM; i++) offs_q[i] <= use_c[i*ROW+CH_NUM];
                v2_q    <= v1_q;
                last2_q <= last1_q;
                user2_q <= user1_q;
                byp2_q  <= byp1_q;
                px2_q   <= px1_q;
                acc_q   <= acc_d;
                v3_q    <= v2_q;
                last3_q <= last2_q;
                user3_q <= user2_q;
                dat_q   <= dat_d;
            end
        end
    end

    assign s_tready_o   = en;
    assign m_tvalid_o   = v3_q;
    assign m_tdata_o    = dat_q;
    assign m_tlast_o    = last3_q;
    assign m_tuser_o    = user3_q;
    assign coef_rdata_o = rdata_q;
    assign coef_pend_o  = pend_q;
endmodule

// File: tb/tb_color_matrix_nch.sv
// Randomised bench for color_matrix_nch against an integer-arithmetic reference with a beat scoreboard.
module tb_color_matrix_nch;
    localparam int NC = 12;

    logic        clk = 1'b0;
    logic        rst_n, s_tvalid, s_tready, s_tlast, s_tuser;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic        bypass, coef_wr, coef_apply, coef_pend;
    logic [31:0] s_tdata, m_tdata;
    logic [3:0]  coef_addr;
    logic [21:0] coef_wdata, coef_rdata;

    always #5 clk = ~clk;

    color_matrix_nch dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
        .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
        .m_tlast_o(m_tlast), .m_tuser_o(m_tuser),
        .bypass_i(bypass), .coef_wr_i(coef_wr), .coef_addr_i(coef_addr),
        .coef_wdata_i(coef_wdata), .coef_rdata_o(coef_rdata),
        .coef_apply_i(coef_apply), .coef_pend_o(coef_pend)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
        logic        user;
    } beat_t;

    beat_t       q[$];
    int          act[NC], shd[NC];
    bit          pend;
    logic [31:0] rd_exp;
    int          n_chk = 0, n_fail = 0, n_out = 0;

    bit          t_rst, t_vld, t_last, t_user, t_byp, t_wr, t_apply, t_mrdy;
    logic [31:0] t_dat;
    logic [3:0]  t_addr;
    logic [21:0] t_wdata;
    bit          rand_rdy, last_hs, saw_out;
    int          stall_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v, input int w);
        int m = v & ((1 << w) - 1);
        if (((m >> (w - 1)) & 1) != 0) m -= (1 << w);
        return m;
    endfunction

    function automatic logic [31:0] ref_px(input logic [31:0] d, input bit byp);
        logic [31:0] r = '0;
        longint      s;
        if (byp) return {2'b00, d[29:0]};
        for (int i = 0; i < 3; i++) begin
            s = longint'(act[i*4+3]);
            for (int j = 0; j < 3; j++) s += longint'(act[i*4+j]) * longint'(d[j*10 +: 10]);
            s = (s + 512) >>> 10;
            if (s < 0) s = 0;
            else if (s > 1023) s = 1023;
            r[i*10 +: 10] = s[9:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) act[k] = (k % 4 == k / 4) ? 1024 : 0;
        shd    = act;
        pend   = 0;
        rd_exp = '0;
        q.delete();
    endtask

    // One clock: drive at negedge, observe and update the model, then the posedge follows.
    task automatic step();
        bit          hs, empty, copy;
        logic [31:0] rd_next;
        @(negedge clk);
        if (stall_cnt > 0) begin
            t_mrdy = 0;
            stall_cnt--;
        end else begin
            t_mrdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        rst_n = t_rst;   s_tvalid = t_vld;  s_tdata = t_dat;  s_tlast = t_last;
        s_tuser = t_user; bypass = t_byp;   m_tready = t_mrdy;
        coef_wr = t_wr;  coef_addr = t_addr; coef_wdata = t_wdata; coef_apply = t_apply;
        #1;
        last_hs = 0;
        saw_out = 0;
        if (!t_rst) begin
            model_reset();
            return;
        end
        chk("coef_pend", coef_pend, pend);
        chk("coef_rdata", coef_rdata, rd_exp);
        if (t_mrdy) chk("s_tready", s_tready, 1);
        else if (m_tvalid) chk("s_tready_stall", s_tready, 0);
        empty = (q.size() == 0);
        if (m_tvalid) begin
            saw_out = 1;
            if (empty) chk("spurious_beat", m_tvalid, 0);
            else begin
                chk("m_tdata", m_tdata, q[0].dat);
                chk("m_tlast", m_tlast, q[0].last);
                chk("m_tuser", m_tuser, q[0].user);
                if (t_mrdy) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        hs      = t_vld && s_tready;
        last_hs = hs;
        copy    = ((pend || t_apply) && hs && t_user) || (pend && empty && !t_vld);
        rd_next = (t_addr < NC) ? (act[t_addr] & 32'h3FFFFF) : 32'h0;
        if (copy) act = shd;
        if (t_wr && t_addr < NC)
            shd[t_addr] = (t_addr % 4 == 3) ? sx(int'(t_wdata), 22) : sx(int'(t_wdata), 14);
        pend = !copy && (pend || t_apply);
        if (hs) q.push_back(beat_t'{ref_px(t_dat, t_byp), t_last, t_user});
        rd_exp = rd_next;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit user, input bit last, input bit byp,
                             input int max_gap, input bit do_wr, input logic [3:0] wa,
                             input logic [21:0] wd, input bit do_apply);
        int n = 0;
        t_vld = 0;
        repeat ($urandom_range(0, max_gap)) step();
        t_dat = d; t_user = user; t_last = last; t_byp = byp; t_vld = 1;
        t_wr = do_wr; t_addr = wa; t_wdata = wd; t_apply = do_apply;
        do begin
            step();
            t_wr = 0;
            t_apply = 0;
            n++;
        end while (!last_hs && n < 200);
        chk("beat_accepted", last_hs, 1);
        t_vld = 0;
    endtask

    task automatic coef_write(input logic [3:0] a, input logic [21:0] v);
        t_vld = 0; t_wr = 1; t_addr = a; t_wdata = v;
        step();
        t_wr = 0;
    endtask

    task automatic apply_idle();
        t_apply = 1;
        step();
        t_apply = 0;
        repeat (2) step();
    endtask

    task automatic drain();
        int n = 0;
        t_vld = 0;
        while (q.size() > 0 && n < 400) begin
            step();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic single(input string tag, input logic [31:0] d, input logic [31:0] exp);
        int lat = 0;
        rand_rdy = 0;
        send_beat(d, 1, 1, 0, 0, 0, 4'd0, 22'd0, 0);
        do begin
            step();
            lat++;
        end while (!saw_out && lat < 20);
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_data"}, m_tdata, exp);
    endtask

    initial begin
        int base;
        t_rst = 0; t_vld = 0; t_last = 0; t_user = 0; t_byp = 0; t_wr = 0; t_apply = 0;
        t_dat = '0; t_addr = '0; t_wdata = '0; rand_rdy = 0; stall_cnt = 0;
        repeat (2) step();
        t_rst = 1;
        step();
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tuser", m_tuser, 0);

        single("identity", {2'b0, 10'd300, 10'd200, 10'd100}, {2'b0, 10'd300, 10'd200, 10'd100});

        coef_write(4'd0, 22'h007C00);
        coef_write(4'd3, 22'h0FFE00);
        apply_idle();
        t_addr = 4'd0;
        repeat (2) step();
        chk("rdata_a00_neg1", coef_rdata, 22'h3FFC00);
        single("clip_high", {2'b0, 10'd9, 10'd7, 10'd0}, {2'b0, 10'd9, 10'd7, 10'd1023});
        single("round_half_up", {2'b0, 10'd9, 10'd7, 10'd5}, {2'b0, 10'd9, 10'd7, 10'd1019});

        coef_write(4'd0, 22'h000400);
        coef_write(4'd3, 22'h000000);
        coef_write(4'd5, 22'h000800);
        coef_write(4'd11, 22'h3F3800);
        apply_idle();
        single("clip_hi_lo", {2'b0, 10'd20, 10'd600, 10'd50}, {2'b0, 10'd0, 10'd1023, 10'd50});

        coef_write(4'd5, 22'h000400);
        coef_write(4'd11, 22'h000000);
        apply_idle();
        base = n_out;
        rand_rdy = 0;
        for (int k = 0; k < 64; k++) begin
            if (k == 30) stall_cnt = 5;
            send_beat($urandom, k == 0, k == 63, 1'($urandom_range(0, 1)), 0, 0, 4'd0, 22'd0, 0);
        end
        drain();
        chk("line_beats_out", n_out - base, 64);

        rand_rdy = 1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin
                send_beat($urandom, k == 0, k == 15, 0, 0, (f == 0 && k == 5), 4'd0, 22'h000200,
                          (f == 0 && k == 8));
                if (f == 0 && k == 9) chk("pend_set", coef_pend, 1);
            end
        end
        drain();
        chk("pend_cleared", coef_pend, 0);

        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 20; k++) begin
                logic [3:0]  wa = 4'($urandom_range(0, 13));
                logic [21:0] wd;
                if (wa % 4 == 3) wd = 22'($urandom_range(0, 2 ** 20) - 2 ** 19);
                else wd = 22'($urandom_range(0, 4095) - 2048);
                send_beat($urandom, k == 0, (k % 10) == 9, 1'($urandom_range(0, 3) == 0), 2,
                          $urandom_range(0, 3) == 0, wa, wd, $urandom_range(0, 15) == 0);
            end
        end
        drain();

        rand_rdy = 0;
        send_beat($urandom, 1, 0, 0, 0, 0, 4'd0, 22'd0, 0);
        send_beat($urandom, 0, 0, 0, 0, 0, 4'd0, 22'd0, 1);
        t_rst = 0;
        step();
        t_rst = 1;
        step();
        chk("rst_flush_vld", m_tvalid, 0);
        step();
        chk("rst_rdata_a00", coef_rdata, 22'h000400);
        repeat (10) step();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
